// File: rtl/dm_pkg.sv
// Shared types, constants and the byte-lane merge rule for the data-memory responder.
package dm_pkg;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

  localparam int          DM_ADDR_WIDTH = 12;
  localparam logic [31:0] DM_WORD_MASK  = 32'hFFFF_FFFC;

  // Lane i takes wdata when byteen[i] is set, otherwise keeps the old byte.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) result[8*i +: 8] = wdata[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge; one instance feeds both the array write and the store trace.
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged_word
);

  assign merged_word = byte_merge(old_word, wdata, byteen);

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word read, lane-merged synchronous write,
// post-reset clear sequence and a registered store-commit trace.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH     = DM_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        busy,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  dm_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr_reg, clr_ptr_next;

  logic [ADDR_WIDTH-1:0] index;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic                  clear_en;
  logic                  store_en;

  // Upper address bits are dropped on purpose, so the array aliases.
  assign index    = m_data_addr[ADDR_WIDTH+1:2];
  assign old_word = mem[index];

  assign busy         = (state_reg == DM_CLEAR);
  assign m_data_rdata = busy ? 32'h0 : old_word;
  assign clear_en     = busy && !reset;
  assign store_en     = !busy && !reset && (|m_data_byteen);

  dm_byte_merge u_merge (
    .old_word    (old_word),
    .wdata       (m_data_wdata),
    .byteen      (m_data_byteen),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR_ON_RESET ? DM_CLEAR : DM_READY;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == DM_CLEAR) begin
      clr_ptr_next = clr_ptr_reg + 1'b1;
      if (clr_ptr_reg == {ADDR_WIDTH{1'b1}}) state_next = DM_READY;
    end
  end

  // Single write port shared by the clear sweep and CPU stores.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[clr_ptr_reg] <= 32'h0;
    end else if (store_en) begin
      mem[index] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= 32'h0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
    end else begin
      trace_valid <= store_en;
      if (store_en) begin
        trace_pc   <= m_inst_addr;
        trace_addr <= m_data_addr & DM_WORD_MASK;
        trace_data <= merged_word;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: vector table for stores/reads, scoreboard for the trace.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        busy;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic [31:0] exp_old;
    logic [31:0] exp_word;
    logic [31:0] exp_taddr;
  } vec_t;

  trace_t sb[$];
  vec_t   vecs[8];

  always #5 clk = ~clk;

  dm_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .busy          (busy),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and compare the trace against the scoreboard.
  task automatic step();
    trace_t t;
    logic   exp_v;
    @(posedge clk);
    #1;
    exp_v = (sb.size() != 0);
    chk("trace_valid", {31'b0, trace_valid}, {31'b0, exp_v});
    if (exp_v) begin
      t = sb.pop_front();
      chk("trace_pc", trace_pc, t.pc);
      chk("trace_addr", trace_addr, t.addr);
      chk("trace_data", trace_data, t.data);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = be;
    m_inst_addr   = pc;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    trace_t t;

    vecs[0] = '{32'h0000_0010, 32'h1234_5678, 4'hF, 32'h3004, 32'h0,         32'h1234_5678, 32'h10};
    vecs[1] = '{32'h0000_0010, 32'h00AB_0000, 4'h4, 32'h3008, 32'h1234_5678, 32'h12AB_5678, 32'h10};
    vecs[2] = '{32'h0000_0012, 32'h0000_BEEF, 4'h3, 32'h300C, 32'h12AB_5678, 32'h12AB_BEEF, 32'h10};
    vecs[3] = '{32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h3010, 32'h0,         32'hDEAD_BEEF, 32'h20};
    vecs[4] = '{32'h0000_0024, 32'hA1B2_C3D4, 4'hA, 32'h3014, 32'h0,         32'hA100_C300, 32'h24};
    vecs[5] = '{32'h0000_0024, 32'h0,         4'h0, 32'h3018, 32'hA100_C300, 32'hA100_C300, 32'h24};
    vecs[6] = '{32'h0000_4024, 32'h5566_7788, 4'h5, 32'h301C, 32'hA100_C300, 32'hA166_C388, 32'h4024};
    vecs[7] = '{32'h0000_3FFD, 32'hFFFF_FFFF, 4'h8, 32'h3020, 32'h0,         32'hFF00_0000, 32'h3FFC};

    reset = 1'b1;
    drive(32'h0, 32'h0, 4'h0, 32'h0);
    step();
    step();
    chk("reset_busy", {31'b0, busy}, 32'h1);
    chk("reset_rdata", m_data_rdata, 32'h0);
    chk("reset_trace_pc", trace_pc, 32'h0);
    reset = 1'b0;

    // Clear sweep; a store attempted mid-sweep must be dropped.
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (n == 0) chk("clear_rdata0", m_data_rdata, 32'h0);
      if (n == 100) drive(32'h40, 32'hFFFF_FFFF, 4'hF, 32'h2000);
      if (n == 101) drive(32'h0, 32'h0, 4'h0, 32'h0);
      step();
      n++;
    end
    chk("clear_cycles", n, 32'd4096);
    $display("clear done after %0d busy cycles", n);
    chk("ready_busy", {31'b0, busy}, 32'h0);
    drive(32'h40, 32'h0, 4'h0, 32'h0);
    #1 chk("busy_store_dropped", m_data_rdata, 32'h0);
    drive(32'h3FFC, 32'h0, 4'h0, 32'h0);
    #1 chk("clear_top_word", m_data_rdata, 32'h0);

    // Vector table: back-to-back stores, each checked for read-during-write.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].pc);
      #1 chk($sformatf("vec%0d_old", i), m_data_rdata, vecs[i].exp_old);
      if (vecs[i].be != 4'h0) begin
        t.pc   = vecs[i].pc;
        t.addr = vecs[i].exp_taddr;
        t.data = vecs[i].exp_word;
        sb.push_back(t);
      end
      step();
      m_data_byteen = 4'h0;
      #1 chk($sformatf("vec%0d_new", i), m_data_rdata, vecs[i].exp_word);
      $display("vec %0d addr=%h be=%b wdata=%h -> rdata=%h trace_valid=%0b",
               i, vecs[i].addr, vecs[i].be, vecs[i].wdata, m_data_rdata, trace_valid);
    end
    step();

    // Store high in the array, then reset mid-clear and confirm the full restart.
    drive(32'h3000, 32'hCAFE_F00D, 4'hF, 32'h4000);
    t.pc = 32'h4000; t.addr = 32'h3000; t.data = 32'hCAFE_F00D;
    sb.push_back(t);
    step();
    m_data_byteen = 4'h0;
    #1 chk("pre_reset_word", m_data_rdata, 32'hCAFE_F00D);
    $display("store addr=3000 data=cafef00d committed");

    reset = 1'b1;
    step();
    chk("rst_trace_pc", trace_pc, 32'h0);
    chk("rst_trace_addr", trace_addr, 32'h0);
    chk("rst_trace_data", trace_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_rdata", m_data_rdata, 32'h0);
    reset = 1'b0;
    repeat (100) step();
    chk("midclear_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(n);
    chk("restart_cycles", n, 32'd4096);
    $display("restart clear done after %0d busy cycles", n);
    #1 chk("restart_word_cleared", m_data_rdata, 32'h0);
    drive(32'h10, 32'h0, 4'h0, 32'h0);
    #1 chk("restart_low_cleared", m_data_rdata, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Synthesizable data-memory responder for the CPU data port (m_data_addr/wdata/byteen → m_data_rdata); the memory-side end of the interface the CPU drives.
- Provides combinational word read and byte-lane-merged synchronous write.
- Zeroes its array with a post-reset clear FSM and signals `busy` while clearing.
- Emits a registered store-commit trace (pc, word address, merged word) for logging and checking.

Parameters:
- ADDR_WIDTH, 12, word-address bits; DEPTH = 2**ADDR_WIDTH words (4096).
- CLEAR_ON_RESET, 1, 1 = run the clear FSM after reset; 0 = skip clearing and keep contents.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_data_addr  in  32  byte address from CPU MEM stage
- m_data_wdata  in  32  store data, already lane-aligned by CPU
- m_data_byteen  in  4  byte-lane write enables; 4'b0000 = no write
- m_inst_addr  in  32  PC of instruction in MEM stage
- m_data_rdata  out  32  read word
- busy  out  1  high while clearing; CPU must stall MEM accesses
- trace_valid  out  1  one-cycle pulse per committed store
- trace_pc  out  32  PC of committed store
- trace_addr  out  32  word-aligned address of committed store
- trace_data  out  32  full merged word written

Behaviour:
- Reset (reset=1 at posedge):
  - state ← CLEAR if CLEAR_ON_RESET, else READY; clr_ptr ← 0.
  - trace_valid ← 0; trace_pc, trace_addr, trace_data ← 0.
  - busy = 1 if CLEAR_ON_RESET, else 0.
- Index rule: word index = m_data_addr[ADDR_WIDTH+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so the array aliases.
- CLEAR state:
  - Each non-reset cycle: mem[clr_ptr] ← 0, then clr_ptr ← clr_ptr+1.
  - After writing index DEPTH-1, state ← READY.
  - busy=1 for exactly DEPTH cycles after the first cycle with reset=0.
  - While busy: m_data_rdata = 0, byteen is ignored (no write), trace_valid stays 0.
  - Reset asserted mid-clear restarts at clr_ptr=0.
- READY state:
  - m_data_rdata = mem[index], combinational, no latency.
  - Write: if |m_data_byteen, then at posedge mem[index] ← merged word. Merge rule: lane i comes from wdata[8i+7:8i] when byteen[i]=1, otherwise from the current mem[index].
  - Read-during-write at the same index: rdata shows the old word in that cycle and the new word from the next cycle.
- Trace:
  - Registered on the same edge as the write.
  - Next cycle: trace_valid=1, trace_pc=m_inst_addr, trace_addr=m_data_addr & 32'hFFFF_FFFC, trace_data=merged word.
  - trace_valid returns to 0 in the following cycle unless another store commits.
  - Back-to-back stores produce back-to-back pulses.
- byteen=0 in READY: no write, trace_valid=0 next cycle.
- Non-contiguous byteen patterns (e.g. 4'b1010) are legal and merge per lane.
- FSM states are CLEAR and READY only. READY → CLEAR happens only via reset.

Decomposition:
- Shared package dm_pkg contains:
  - state enum {DM_CLEAR, DM_READY}
  - DM_ADDR_WIDTH default
  - word-align mask 32'hFFFF_FFFC
  - function byte_merge(old, wdata, byteen)
- Optional sub-module dm_byte_merge, purely combinational lane merge, reused by the trace path and the write path.

Test Plan:
- Clear after reset: reset 2 cycles, then release → busy=1 for 4096 cycles, rdata=0 at addr 0x0; busy falls; read 0x3FFC → 0.
- Full-word store: READY, addr=0x10, wdata=0x12345678, byteen=4'hF, pc=0x3004 → next cycle trace_valid=1, trace_pc=0x3004, trace_addr=0x10, trace_data=0x12345678; rdata@0x10 = 0x12345678.
- Byte/half merge: mem[0x10]=0x12345678.
  - sb: byteen=4'b0100, wdata=0x00AB0000 → word becomes 0x12AB5678.
  - sh: byteen=4'b0011, wdata=0x0000BEEF, addr=0x12 → trace_addr=0x10, word 0x12ABBEEF.
- Read-during-write: store 0xDEADBEEF to 0x20 while reading 0x20 → same cycle rdata=old value, next cycle 0xDEADBEEF.
- Store ignored while busy: byteen=4'hF at addr 0x40 during CLEAR → trace_valid stays 0, rdata@0x40 = 0 after clear.
- Reset mid-clear: assert reset at clr_ptr=100 → busy remains 1 for a full 4096 further cycles after release; a word stored before that reset reads 0 afterwards.
